// File: rtl/serv_rf_dbg_arb.sv
// Shares RF port 0 between the core and a debug requester doing bit-serial 32-bit register reads/writes.
// Optional WAIT timeout is enabled by defining SERV_RF_DBG_ARB_TIMEOUT_EN.
module serv_rf_dbg_arb #(
  parameter int WITH_CSR = 1,
  parameter int RDLAT    = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [5+WITH_CSR-1:0] i_core_rreg0,
  input  logic [5+WITH_CSR-1:0] i_core_wreg0,
  input  logic                  i_core_wen0,
  input  logic                  i_core_wdata0,
  input  logic                  i_core_idle,
  output logic                  o_core_stall,
  output logic                  o_core_rdata0,
  output logic [5+WITH_CSR-1:0] o_rreg0,
  output logic [5+WITH_CSR-1:0] o_wreg0,
  output logic                  o_wen0,
  output logic                  o_wdata0,
  input  logic                  i_rdata0,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_write,
  input  logic [5+WITH_CSR-1:0] i_dbg_addr,
  input  logic [31:0]           i_dbg_wdata,
  output logic                  o_dbg_busy,
  output logic                  o_dbg_ack,
  output logic                  o_dbg_err,
  output logic [31:0]           o_dbg_rdata
);

  localparam int AW = 5 + WITH_CSR;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

  state_t        state;
  logic [5:0]    cnt;
  logic [31:0]   shreg;
  logic [AW-1:0] addr;
  logic          is_write;
  logic [5:0]    last_idx;
  logic [31:0]   shreg_rd;
  logic          xfer;

`ifdef SERV_RF_DBG_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
  logic       err_q;
  assign o_dbg_err = err_q;
`else
  logic [7:0] timeout_unused;
  assign timeout_unused = 8'(TIMEOUT);
  assign o_dbg_err      = 1'b0;
`endif

  // Reads spend RDLAT extra cycles before the first valid RF bit arrives.
  assign last_idx = is_write ? 6'd31 : 6'(RDLAT + 31);
  assign shreg_rd = {i_rdata0, shreg[31:1]};
  assign xfer     = (state == XFER);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      addr         <= '0;
      is_write     <= 1'b0;
      o_dbg_busy   <= 1'b0;
      o_core_stall <= 1'b0;
      o_dbg_ack    <= 1'b0;
      o_dbg_rdata  <= '0;
`ifdef SERV_RF_DBG_ARB_TIMEOUT_EN
      wait_cnt     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      o_dbg_ack <= 1'b0;
`ifdef SERV_RF_DBG_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (i_dbg_req) begin
            is_write     <= i_dbg_write;
            addr         <= i_dbg_addr;
            shreg        <= i_dbg_wdata;
            o_dbg_busy   <= 1'b1;
            o_core_stall <= 1'b1;
`ifdef SERV_RF_DBG_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (i_core_idle) begin
            cnt   <= '0;
            state <= XFER;
          end
`ifdef SERV_RF_DBG_ARB_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            o_dbg_ack <= 1'b1;
            err_q     <= 1'b1;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        XFER: begin
          cnt <= cnt + 6'd1;
          if (is_write)
            shreg <= {1'b0, shreg[31:1]};
          else if (cnt >= 6'(RDLAT))
            shreg <= shreg_rd;
          if (cnt == last_idx) begin
            o_dbg_ack <= 1'b1;
            if (!is_write)
              o_dbg_rdata <= shreg_rd;
            state <= DONE;
          end
        end
        DONE: begin
          o_dbg_busy   <= 1'b0;
          o_core_stall <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Debug owns port 0 only during XFER; writes to x0 are suppressed but still take 32 cycles.
  always_comb begin
    o_rreg0  = i_core_rreg0;
    o_wreg0  = i_core_wreg0;
    o_wen0   = i_core_wen0;
    o_wdata0 = i_core_wdata0;
    if (xfer) begin
      o_rreg0  = addr;
      o_wreg0  = addr;
      o_wen0   = is_write && (addr != '0);
      o_wdata0 = shreg[0];
    end
  end

  assign o_core_rdata0 = i_rdata0;

endmodule

// File: tb/tb_serv_rf_dbg_arb.sv
// Randomized self-checking bench for serv_rf_dbg_arb against a word-level RF model.
// Timeout path is exercised when SERV_RF_DBG_ARB_TIMEOUT_EN is defined.
module tb_serv_rf_dbg_arb;

  localparam int WITH_CSR = 1;
  localparam int RDLAT    = 2;
  localparam int TIMEOUT  = 16;
  localparam int AW       = 5 + WITH_CSR;
`ifdef SERV_RF_DBG_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [AW-1:0] i_core_rreg0, i_core_wreg0;
  logic          i_core_wen0, i_core_wdata0, i_core_idle;
  logic          o_core_stall, o_core_rdata0;
  logic [AW-1:0] o_rreg0, o_wreg0;
  logic          o_wen0, o_wdata0, i_rdata0;
  logic          i_dbg_req, i_dbg_write;
  logic [AW-1:0] i_dbg_addr;
  logic [31:0]   i_dbg_wdata;
  logic          o_dbg_busy, o_dbg_ack, o_dbg_err;
  logic [31:0]   o_dbg_rdata;

  serv_rf_dbg_arb #(.WITH_CSR(WITH_CSR), .RDLAT(RDLAT), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_core_rreg0(i_core_rreg0), .i_core_wreg0(i_core_wreg0),
    .i_core_wen0(i_core_wen0), .i_core_wdata0(i_core_wdata0), .i_core_idle(i_core_idle),
    .o_core_stall(o_core_stall), .o_core_rdata0(o_core_rdata0),
    .o_rreg0(o_rreg0), .o_wreg0(o_wreg0), .o_wen0(o_wen0), .o_wdata0(o_wdata0),
    .i_rdata0(i_rdata0),
    .i_dbg_req(i_dbg_req), .i_dbg_write(i_dbg_write), .i_dbg_addr(i_dbg_addr),
    .i_dbg_wdata(i_dbg_wdata),
    .o_dbg_busy(o_dbg_busy), .o_dbg_ack(o_dbg_ack), .o_dbg_err(o_dbg_err),
    .o_dbg_rdata(o_dbg_rdata)
  );

  always #5 i_clk = ~i_clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rf_model [64];
  logic [31:0] last_rdata;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flags packed as {busy, stall, ack, err}.
  task automatic checkFlags(input string tag, input logic [3:0] exp);
    checkOutput(tag, {28'd0, o_dbg_busy, o_core_stall, o_dbg_ack, o_dbg_err}, {28'd0, exp});
  endtask

  task automatic checkPass(input string tag);
    checkOutput(tag, {17'd0, o_rreg0, o_wreg0, o_wen0, o_wdata0, o_core_rdata0},
                     {17'd0, i_core_rreg0, i_core_wreg0, i_core_wen0, i_core_wdata0, i_rdata0});
  endtask

  task automatic nextCycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus();
    i_core_rreg0  = AW'($urandom);
    i_core_wreg0  = AW'($urandom);
    i_core_wen0   = 1'($urandom);
    i_core_wdata0 = 1'($urandom);
    i_rdata0      = 1'($urandom);
  endtask

  // One full debug command from an IDLE window through the return to IDLE.
  task automatic runCmd(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                        input int delay, input bit hold_req);
    bit timed_out;
    int wait_windows;
    int n;
    timed_out    = TO_EN && (delay >= TIMEOUT);
    wait_windows = timed_out ? TIMEOUT : delay + 1;
    i_dbg_req   = 1'b1;
    i_dbg_write = wr;
    i_dbg_addr  = a;
    i_dbg_wdata = d;
    i_core_idle = (delay == 0);
    applyStimulus();
    settle();
    checkFlags("idle_flags", 4'b0000);
    checkPass("idle_pass");
    for (int w = 1; w <= wait_windows; w++) begin
      nextCycle();
      i_dbg_req   = hold_req ? 1'($urandom) : 1'b0;
      i_dbg_write = 1'($urandom);
      i_dbg_addr  = AW'($urandom);
      i_dbg_wdata = $urandom;
      i_core_idle = (w > delay);
      applyStimulus();
      settle();
      checkFlags($sformatf("wait%0d_flags", w), 4'b1100);
      checkPass($sformatf("wait%0d_pass", w));
    end
    if (!timed_out) begin
      n = wr ? 32 : RDLAT + 32;
      for (int c = 0; c < n; c++) begin
        nextCycle();
        i_dbg_req   = hold_req ? 1'($urandom) : 1'b0;
        i_core_idle = 1'($urandom);
        applyStimulus();
        if (!wr && c >= RDLAT) i_rdata0 = rf_model[a][c-RDLAT];
        settle();
        checkFlags($sformatf("xfer%0d_flags", c), 4'b1100);
        checkOutput($sformatf("xfer%0d_regs", c), {20'd0, o_rreg0, o_wreg0}, {20'd0, a, a});
        checkOutput($sformatf("xfer%0d_wen", c), {31'd0, o_wen0}, {31'd0, wr && (a != '0)});
        if (wr) checkOutput($sformatf("xfer%0d_wdata", c), {31'd0, o_wdata0}, {31'd0, d[c]});
      end
      if (wr && a != '0) rf_model[a] = d;
      if (!wr) last_rdata = rf_model[a];
    end
    nextCycle();
    i_dbg_req   = 1'b0;
    i_core_idle = 1'($urandom);
    applyStimulus();
    settle();
    checkFlags("done_flags", {3'b111, timed_out});
    checkOutput("done_rdata", o_dbg_rdata, last_rdata);
    checkPass("done_pass");
    nextCycle();
    applyStimulus();
    settle();
    checkFlags("after_flags", 4'b0000);
    checkOutput("after_rdata", o_dbg_rdata, last_rdata);
    checkPass("after_pass");
  endtask

  initial begin
    logic [31:0] core_word;
    logic [31:0] d7;
    i_rst_n     = 1'b0;
    i_core_idle = 1'b0;
    i_dbg_req   = 1'b0;
    i_dbg_write = 1'b0;
    i_dbg_addr  = '0;
    i_dbg_wdata = '0;
    applyStimulus();
    for (int r = 0; r < 64; r++) rf_model[r] = (r == 0) ? 32'd0 : $urandom;
    last_rdata = 32'd0;

    nextCycle();
    checkFlags("reset_flags", 4'b0000);
    checkOutput("reset_rdata", o_dbg_rdata, 32'd0);
    nextCycle();
    i_rst_n = 1'b1;
    nextCycle();

    $display("[TB] write x5, read back via core and via debug");
    runCmd(1'b1, 6'd5, 32'hA5A5_1234, 0, 1'b1);
    i_core_rreg0 = 6'd5;
    core_word    = 32'd0;
    for (int c = 0; c < 32; c++) begin
      nextCycle();
      i_rdata0 = rf_model[5][c];
      settle();
      core_word[c] = o_core_rdata0;
    end
    checkOutput("core_read_x5", core_word, 32'hA5A5_1234);
    nextCycle();
    runCmd(1'b0, 6'd5, 32'h0, 0, 1'b1);
    checkOutput("dbg_read_x5", o_dbg_rdata, 32'hA5A5_1234);

    $display("[TB] x0 write is dropped");
    runCmd(1'b1, 6'd0, 32'hFFFF_FFFF, 0, 1'b0);
    runCmd(1'b0, 6'd0, 32'h1234_5678, 1, 1'b0);
    checkOutput("dbg_read_x0", o_dbg_rdata, 32'd0);

    $display("[TB] long waits for core idle");
    runCmd(1'b1, 6'd9, 32'hDEAD_BEEF, 20, 1'b0);
    runCmd(1'b0, 6'd9, 32'h0, 40, 1'b1);

    $display("[TB] reset in the middle of a write");
    d7 = $urandom;
    i_dbg_req   = 1'b1;
    i_dbg_write = 1'b1;
    i_dbg_addr  = 6'd7;
    i_dbg_wdata = d7;
    i_core_idle = 1'b1;
    nextCycle();
    i_dbg_req = 1'b0;
    for (int c = 0; c <= 10; c++) nextCycle();
    applyStimulus();
    i_rst_n = 1'b0;
    settle();
    checkFlags("midrst_flags", 4'b0000);
    checkOutput("midrst_rdata", o_dbg_rdata, 32'd0);
    checkPass("midrst_pass");
    rf_model[7] = {rf_model[7][31:10], d7[9:0]};
    last_rdata  = 32'd0;
    nextCycle();
    nextCycle();
    i_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      nextCycle();
      applyStimulus();
      settle();
      checkFlags($sformatf("postrst%0d_flags", c), 4'b0000);
    end
    runCmd(1'b0, 6'd7, 32'h0, 0, 1'b0);

    $display("[TB] randomized commands");
    for (int k = 0; k < 25; k++) begin
      runCmd(1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, 24)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
